// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and index-width helper
package seg_pkg;

  // Active-high segments {g,f,e,d,c,b,a}, indexed by hex value 0..F
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational digit value to active-high a..g decoder
module seg_hex_decode
  import seg_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] value,
  output logic [6:0]        seg
);

  logic over;

  generate
    if (DATA_W > 4) begin : g_wide
      assign over = |value[DATA_W-1:4];
    end else begin : g_narrow
      assign over = 1'b0;
    end
  endgenerate

  // Anything that does not fit in one hex digit shows a dash
  assign seg = over ? SEG_DASH : SEG_HEX[value[3:0]];

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed seven-segment scan driver with per-frame snapshot
// Define SEG_SCAN_LZB_EN to blank leading zero digits at snapshot time.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [NUM_DIGITS*DATA_W-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  input  logic [NUM_DIGITS-1:0]          blank_in,
  output logic [NUM_DIGITS-1:0]          dig_n,
  output logic [7:0]                     seg_n,
  output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
  output logic                           frame_start
);

  localparam int IDX_W = clog2_min1(NUM_DIGITS);
  localparam int DIV_W = clog2_min1(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  need_init;
  logic [DATA_W-1:0]     snap_val [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp;
  logic [NUM_DIGITS-1:0] snap_blank;
  logic [NUM_DIGITS-1:0] lzb_mask;
  logic                  tick;
  logic                  wrap;
  logic                  snap;
  logic                  dark;
  logic [DATA_W-1:0]     cur_val;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] dig_nxt;
  logic [7:0]            seg_nxt;

  assign tick = en && (div_cnt == LAST_DIV);
  assign wrap = tick && (idx_q == LAST_IDX);
  assign snap = en && (need_init || wrap);
  // Dark on every index change so the old segments never light the new digit
  assign dark = !en || tick || snap;

  assign digit_idx = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      idx_q     <= '0;
      need_init <= 1'b1;
    end else if (en) begin
      need_init <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  always_comb begin
    logic leading;
    lzb_mask = '0;
    leading  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (leading && (data_in[k*DATA_W +: DATA_W] == '0) && !dp_in[k]) begin
        lzb_mask[k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  assign lzb_mask = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) snap_val[k] <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap;
      if (snap) begin
        for (int k = 0; k < NUM_DIGITS; k++) snap_val[k] <= data_in[k*DATA_W +: DATA_W];
        snap_dp    <= dp_in;
        snap_blank <= blank_in | lzb_mask;
      end
    end
  end

  assign cur_val = snap_val[idx_q];

  seg_hex_decode #(.DATA_W(DATA_W)) u_dec (
    .value (cur_val),
    .seg   (cur_seg)
  );

  // Blanked digits keep their enable so per-digit drive current stays constant
  always_comb begin
    dig_nxt = '1;
    seg_nxt = SEG_OFF;
    if (!dark) begin
      dig_nxt[idx_q] = 1'b0;
      if (!snap_blank[idx_q]) begin
        seg_nxt = ~{snap_dp[idx_q], cur_seg};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_n <= '1;
      seg_n <= SEG_OFF;
    end else begin
      dig_n <= dig_nxt;
      seg_n <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

  localparam int ND = 6;
  localparam int DW = 5;
  localparam int SD = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              en = 1'b0;
  logic [ND*DW-1:0]  data_in = '0;
  logic [ND-1:0]     dp_in = '0;
  logic [ND-1:0]     blank_in = '0;
  logic [ND-1:0]     dig_n;
  logic [7:0]        seg_n;
  logic [$clog2(ND)-1:0] digit_idx;
  logic              frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model: n counts enabled clock edges since reset
  int            n;
  logic [DW-1:0] m_val [ND];
  logic          m_dp [ND];
  logic          m_blank [ND];
  logic          m_fs;
  logic          m_dark;
  logic [7:0]    hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg_scan_mux #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .dig_n       (dig_n),
    .seg_n       (seg_n),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_fs = 1'b0;
    m_dark = 1'b1;
    for (int k = 0; k < ND; k++) begin
      m_val[k] = '0;
      m_dp[k] = 1'b0;
      m_blank[k] = 1'b0;
    end
  endtask

  task automatic model_snap();
    logic lead;
    for (int k = 0; k < ND; k++) begin
      m_val[k]   = data_in[k*DW +: DW];
      m_dp[k]    = dp_in[k];
      m_blank[k] = blank_in[k];
    end
    lead = 1'b1;
`ifdef SEG_SCAN_LZB_EN
    for (int k = ND - 1; k >= 1; k--) begin
      if (lead && m_val[k] == 0 && !m_dp[k]) m_blank[k] = 1'b1;
      else lead = 1'b0;
    end
`endif
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (en) begin
      n++;
      m_fs = (n == 1) || (n % (SD * ND) == 0);
      if (m_fs) model_snap();
      m_dark = (n == 1) || (n % SD == 0);
    end else begin
      m_fs = 1'b0;
      m_dark = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int         idx;
    logic [ND-1:0] ed;
    logic [7:0] es;
    logic [DW-1:0] v;
    idx = (n / SD) % ND;
    ed = '1;
    es = 8'hFF;
    if (!m_dark) begin
      ed[idx] = 1'b0;
      if (!m_blank[idx]) begin
        v = m_val[idx];
        es = (v > 15) ? 8'hBF : hex_tab[v[3:0]];
        if (m_dp[idx]) es[7] = 1'b0;
      end
    end
    check({tag, ".dig_n"}, 32'(dig_n), 32'(ed));
    check({tag, ".seg_n"}, 32'(seg_n), 32'(es));
    check({tag, ".digit_idx"}, 32'(digit_idx), 32'(idx));
    check({tag, ".frame_start"}, 32'(frame_start), 32'(m_fs));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic set_digit(input int k, input logic [DW-1:0] v);
    data_in[k*DW +: DW] = v;
  endtask

  initial begin
    model_reset();
    en = 1'b1;
    for (int k = 0; k < ND; k++) set_digit(k, DW'(k));
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    repeat (2) step("reset_hold");
    rst_n = 1'b1;

    // First frame with digit k = k, then overwrite mid-frame at digit 2
    repeat (26) step("scan");
    for (int i = 0; i < 40 && ((n / SD) % ND) != 2; i++) step("seek2");
    for (int k = 0; k < ND; k++) set_digit(k, 5'h0F);
    repeat (40) step("tear");

    // Dash, decimal point and forced blank
    for (int k = 0; k < ND; k++) set_digit(k, DW'(k + 6));
    set_digit(1, 5'h13);
    dp_in = 6'b000001;
    blank_in = 6'b000100;
    repeat (50) step("dash_dp_blank");

    // Freeze mid-digit
    for (int i = 0; i < 8 && (n % SD) != 2; i++) step("seek_mid");
    en = 1'b0;
    repeat (10) step("en_low");
    en = 1'b1;
    repeat (30) step("resume");

    // Randomized inputs and enable
    repeat (200) begin
      for (int k = 0; k < ND; k++) set_digit(k, DW'($urandom_range(0, 31)));
      dp_in = ND'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? ND'($urandom) : '0;
      en = ($urandom_range(0, 7) != 0);
      step("random");
    end
    en = 1'b1;

    // Asynchronous reset in the middle of a digit
    repeat (7) step("pre_areset");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    step("areset_hold");
    rst_n = 1'b1;
    repeat (30) step("post_areset");

    // Leading-zero pattern 000120
    data_in = '0;
    dp_in = '0;
    blank_in = '0;
    set_digit(1, 5'd2);
    set_digit(2, 5'd1);
    repeat (60) step("lzb");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
